// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default bit timing.
// The transmitter side of the link imports this same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage : uart_pkg

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a delayed copy for
// falling-edge detection. All flops reset to the idle-high line level.
module uart_receiver_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rxs_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Synchroniser chain and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rxs_o  = s2_q;
  assign fall_o = prev_q & ~s2_q;

endmodule : uart_receiver_rx_sync

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit validation at mid-bit, LSB-first data sampling at
// mid-bit, stop-bit check, single-cycle rx_valid / frame_error strobes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  logic rxs;
  logic fall;
  logic half_tick;
  logic full_tick;

  uart_receiver_rx_sync u_rx_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx),
    .rxs_o  (rxs),
    .fall_o (fall)
  );

  assign half_tick = (cnt_q == HALF_M1);
  assign full_tick = (cnt_q == FULL_M1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
        else      state_d = IDLE;
      end
      START: begin
        if (half_tick) state_d = rxs ? IDLE : DATA;
        else           state_d = START;
      end
      DATA: begin
        if (full_tick && (bit_idx_q == LAST_IDX)) state_d = STOP;
        else                                      state_d = DATA;
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed
        if (full_tick) state_d = IDLE;
        else           state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Counter, shift register and strobe next-state
  always_comb begin
    cnt_d     = (state_d != state_q) ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if ((state_q == START) && half_tick && !rxs) begin
      bit_idx_d = {IDX_W{1'b0}};
    end else if ((state_q == DATA) && full_tick) begin
      shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
      bit_idx_d = bit_idx_q + IDX_W'(1);
    end else if ((state_q == STOP) && full_tick) begin
      if (rxs) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ferr_d  = 1'b1;
      end
    end else begin
      bit_idx_d = bit_idx_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      data_q    <= {DATA_BITS{1'b0}};
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit: table of frames
// plus directed sequences for reset, back-to-back, glitch, framing error.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc            = 0;
  int valid_cnt      = 0;
  int ferr_cnt       = 0;
  int busy_cnt       = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_ferr_cyc  = 0;
  int start_cyc      = 0;
  bit prev_strobe    = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (frame_error) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if (rx_valid || frame_error) begin
      check("strobe_exclusive", {31'd0, rx_valid & frame_error}, 32'd0);
      check("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
    end
    prev_strobe = rx_valid | frame_error;
    if (busy) busy_cnt++;
  end

  // Drives one frame starting at the current negedge; optional 1-clk reset mid-bit rst_bit
  task automatic send_frame(input logic [7:0] data, input logic stop, input int rst_bit);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    start_cyc = cyc;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (b == rst_bit && c == 9) begin
          check("midreset_busy",  {31'd0, busy}, 32'd0);
          check("midreset_data",  {24'd0, rx_data}, 32'd0);
          check("midreset_valid", {31'd0, rx_valid}, 32'd0);
          check("midreset_ferr",  {31'd0, frame_error}, 32'd0);
        end
        reset = (b == rst_bit && c == 8);
        @(negedge clk);
      end
    end
    reset = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, f0, b0;
    logic [7:0] d0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  {24'd0, rx_data}, 32'd0);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_ferr",  {31'd0, frame_error}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Long idle-high line
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    idle_gap(1000);
    check("idle_valid", valid_cnt - v0, 32'd0);
    check("idle_ferr",  ferr_cnt - f0, 32'd0);
    check("idle_busy",  busy_cnt - b0, 32'd0);

    for (int i = 0; i < 7; i++) begin
      idle_gap(20);
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, -1);
      check("vec_valid_cnt", valid_cnt - v0, {31'd0, vecs[i].exp_valid});
      check("vec_ferr_cnt",  ferr_cnt - f0,  {31'd0, vecs[i].exp_ferr});
      check("vec_data",      {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      if (vecs[i].exp_valid) check("vec_valid_latency", last_valid_cyc - start_cyc, 32'd155);
      if (vecs[i].exp_ferr)  check("vec_ferr_latency",  last_ferr_cyc - start_cyc, 32'd155);
    end

    // Back-to-back frames, no idle gap
    idle_gap(20);
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, -1);
    check("b2b_first_data", {24'd0, rx_data}, 32'h00);
    send_frame(8'hFF, 1'b1, -1);
    check("b2b_second_data", {24'd0, rx_data}, 32'hFF);
    check("b2b_valid_cnt", valid_cnt - v0, 32'd2);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 32'd160);

    // Short low glitch rejected at mid-start-bit
    idle_gap(20);
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt; d0 = rx_data;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_cycles", busy_cnt - b0, 32'd8);
    check("glitch_strobes", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
    check("glitch_data", {24'd0, rx_data}, {24'd0, d0});
    check("glitch_idle", {31'd0, busy}, 32'd0);

    // Framing error, then line stuck low must not start a frame
    idle_gap(20);
    send_frame(8'h11, 1'b1, -1);
    check("ferr_prior_data", {24'd0, rx_data}, 32'h11);
    idle_gap(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1);
    check("ferr_pulse_cnt", ferr_cnt - f0, 32'd1);
    check("ferr_no_valid", valid_cnt - v0, 32'd0);
    check("ferr_data_held", {24'd0, rx_data}, 32'h11);
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    check("stuck_low_busy", busy_cnt - b0, 32'd0);
    check("stuck_low_strobes", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
    idle_gap(20);
    send_frame(8'h96, 1'b1, -1);
    check("after_stuck_data", {24'd0, rx_data}, 32'h96);
    check("after_stuck_valid", valid_cnt - v0, 32'd1);

    // Reset pulse during data bit 4
    idle_gap(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hF0, 1'b1, 5);
    idle_gap(20);
    check("midreset_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
    check("midreset_data_after", {24'd0, rx_data}, 32'd0);
    send_frame(8'h5A, 1'b1, -1);
    check("post_reset_data", {24'd0, rx_data}, 32'h5A);
    check("post_reset_valid", valid_cnt - v0, 32'd1);
    check("post_reset_latency", last_valid_cyc - start_cyc, 32'd155);
    idle_gap(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_receiver
